seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width (legal 8..64, power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low (one clock; reset asynchronous active-low).
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port alu_ctrl  input  4  operation code.
REQ-007 SHALL have ports op1, op2  input  DATA_WIDTH each  operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port alu_out  output  DATA_WIDTH  result.
REQ-011 SHALL have ports eq, lt, illegal  output  1 each  flags: op1==op2, signed op1<op2, unsupported opcode.

Function
REQ-012 SHALL decode alu_ctrl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT (signed), 0110 SRL, 0111 SRA, 1000 BGE (eq=1 iff signed op1>=op2, alu_out=0), 1001 XOR, 1010 SLTU, 1100 MUL (low half), 1101 MULHU (high half, unsigned), 1110 DIVU, 1111 REMU; 1011 reserved.
REQ-013 SHALL accept a request on a clock edge where in_valid && in_ready, capturing alu_ctrl, op1, op2.
REQ-014 SHALL implement FSM IDLE -> (single-cycle op) DONE; IDLE -> (MUL/MULHU/DIVU/REMU) BUSY -> DONE; DONE -> IDLE when out_ready.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL produce single-cycle ops with out_valid asserted the cycle after acceptance (latency 1).
REQ-017 SHALL compute MUL/MULHU by iterative shift-add and DIVU/REMU by restoring division, each spending exactly DATA_WIDTH cycles in BUSY (latency DATA_WIDTH+1).
REQ-018 SHALL hold alu_out, eq, lt, illegal stable while out_valid=1 and out_ready=0.
REQ-019 SHALL use op2[$clog2(DATA_WIDTH)-1:0] as shift amount; SRA sign-fills.
REQ-020 SHALL wrap ADD/SUB/MUL modulo 2^DATA_WIDTH with no overflow flag.
REQ-021 SHALL return SLT/SLTU results zero-extended (1 or 0).
REQ-022 SHALL on DIVU by zero return all-ones; REMU by zero return op1; both after full DATA_WIDTH+1 latency.
REQ-023 SHALL compute eq and lt from the captured operands for every opcode.
REQ-024 SHALL on reserved opcode go to DONE with latency 1, alu_out=0, illegal=1.
REQ-025 SHALL ignore in_valid while not in IDLE (no queuing).

Reset
REQ-026 SHALL on rst_n=0 immediately force state IDLE, out_valid=0, alu_out=0, eq=0, lt=0, illegal=0, iteration counter=0.
REQ-027 SHALL abandon any in-flight BUSY operation on reset; no result emitted.
REQ-028 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL honour macro SEQ_ALU_MULDIV_EN: defined -> REQ-017/REQ-022 implemented; undefined -> codes 1100-1111 treated as reserved per REQ-024, BUSY state and iterator absent.

Structure
REQ-030 SHALL place in package seq_alu_pkg: alu_op_e enum (4-bit codes of REQ-012) and alu_state_e enum (IDLE, BUSY, DONE).
REQ-031 SHALL isolate the shift-add/restoring-divide datapath in sub-module seq_alu_iter (start, done, mode, operands, result), instantiated only under SEQ_ALU_MULDIV_EN.

Verification
REQ-032 SHALL check ADD 0xFFFFFFFF+0x1 -> alu_out=0, eq=0, lt=1, out_valid one cycle after accept.
REQ-033 SHALL check SRA 0x80000000 by op2=0x24 (shift 4) -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-034 SHALL check MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles; MUL same -> 0x00000001.
REQ-035 SHALL check DIVU 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 100; DIVU 100/7 -> 14, REMU -> 2.
REQ-036 SHALL check back-pressure: out_ready=0 for 5 cycles -> outputs held, in_ready=0, new in_valid ignored.
REQ-037 SHALL check rst_n low at BUSY cycle 10 of DIVU -> out_valid=0 immediately, in_ready=1 after release, no stale result; opcode 1011 -> illegal=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_BGE   = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_RSVD  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per clock for DATA_WIDTH steps.
// Only present when SEQ_ALU_MULDIV_EN is defined.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  alu_op_e               mode_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic                  busy_q;
  logic [CW-1:0]         cnt_q;
  alu_op_e               mode_q;
  logic [DATA_WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [DATA_WIDTH-1:0] hi_d, lo_d;
  logic [DATA_WIDTH:0]   sum, trial;
  logic                  is_div;

  // hi:lo is the product for multiply, remainder:quotient for divide
  assign is_div = (mode_q == OP_DIVU) || (mode_q == OP_REMU);

  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    trial = {hi_q, lo_q[DATA_WIDTH-1]} - {1'b0, opb_q};
    if (is_div) begin
      if (!trial[DATA_WIDTH]) begin
        hi_d = trial[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[DATA_WIDTH:1];
      lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // Result is taken from the final step's next-state so it lands with done_o
  assign done_o   = busy_q && (cnt_q == CW'(DATA_WIDTH - 1));
  assign result_o = ((mode_q == OP_MULHU) || (mode_q == OP_REMU)) ? hi_d : lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      hi_q   <= '0;
      lo_q   <= op1_i;
      opb_q  <= op2_i;
      mode_q <= mode_i;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; MUL/MULHU/DIVU/REMU are iterative
// when SEQ_ALU_MULDIV_EN is defined, otherwise those opcodes report illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  eq,
  output logic                  lt,
  output logic                  illegal
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e                   state_q, state_d;
  alu_op_e                      op_in;
  logic                         accept, muldiv_req;
  logic                         iter_done;
  logic [DATA_WIDTH-1:0]        iter_result;
  logic [DATA_WIDTH-1:0]        res_d, alu_out_q;
  logic                         eq_d, lt_d, illegal_d;
  logic                         eq_q, lt_q, illegal_q;
  logic signed [DATA_WIDTH-1:0] op1_s, op2_s;
  logic [SHW-1:0]               shamt;

  assign op_in  = alu_op_e'(alu_ctrl);
  assign accept = in_valid && in_ready;

`ifdef SEQ_ALU_MULDIV_EN
  assign muldiv_req = (alu_ctrl[3:2] == 2'b11);

  seq_alu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && muldiv_req),
    .mode_i  (op_in),
    .op1_i   (op1),
    .op2_i   (op2),
    .done_o  (iter_done),
    .result_o(iter_result)
  );
`else
  assign muldiv_req  = 1'b0;
  assign iter_done   = 1'b0;
  assign iter_result = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = muldiv_req ? BUSY : DONE;
      BUSY:    if (iter_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    op1_s     = op1;
    op2_s     = op2;
    shamt     = op2[SHW-1:0];
    eq_d      = (op1 == op2);
    lt_d      = (op1_s < op2_s);
    illegal_d = 1'b0;
    res_d     = '0;
    case (op_in)
      OP_ADD:  res_d = op1 + op2;
      OP_SUB:  res_d = op1 - op2;
      OP_AND:  res_d = op1 & op2;
      OP_OR:   res_d = op1 | op2;
      OP_XOR:  res_d = op1 ^ op2;
      OP_SLL:  res_d = op1 << shamt;
      OP_SRL:  res_d = op1 >> shamt;
      OP_SRA:  res_d = op1_s >>> shamt;
      OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, lt_d};
      OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      OP_BGE:  eq_d  = !lt_d;
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: res_d = '0;
`endif
      default: illegal_d = 1'b1;
    endcase
  end

  // Results only change on acceptance or iterator completion, so they hold under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      alu_out_q <= res_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
    end else if ((state_q == BUSY) && iter_done) begin
      alu_out_q <= iter_result;
    end
  end

  assign alu_out = alu_out_q;
  assign eq      = eq_q;
  assign lt      = lt_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu; expectations follow SEQ_ALU_MULDIV_EN when defined.
module tb_seq_alu;

  localparam int W = 32;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, SLL = 4'h4,
                         SLT = 4'h5, SRL = 4'h6, SRA = 4'h7, BGE = 4'h8, XOR_ = 4'h9,
                         SLTU = 4'hA, RSVD = 4'hB, MUL = 4'hC, MULHU = 4'hD,
                         DIVU = 4'hE, REMU = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op1, op2, alu_out;
  logic         eq, lt, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   flg;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op1      (op1),
    .op2      (op2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .eq       (eq),
    .lt       (lt),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa, sb;
    logic [4:0] sh;
    logic [2*W-1:0] prod;
    logic e_eq, e_lt, e_ill;
    sa = a; sb = b; sh = b[4:0];
    e_eq = (a == b); e_lt = (sa < sb); e_ill = 1'b0;
    e.lat = 1; e.res = '0;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      ADD:  e.res = a + b;
      SUB:  e.res = a - b;
      AND_: e.res = a & b;
      OR_:  e.res = a | b;
      XOR_: e.res = a ^ b;
      SLL:  e.res = a << sh;
      SRL:  e.res = a >> sh;
      SRA:  e.res = sa >>> sh;
      SLT:  e.res = e_lt ? 1 : 0;
      SLTU: e.res = (a < b) ? 1 : 0;
      BGE:  e_eq = !e_lt;
`ifdef SEQ_ALU_MULDIV_EN
      MUL:   begin e.res = prod[W-1:0];   e.lat = W + 1; end
      MULHU: begin e.res = prod[2*W-1:W]; e.lat = W + 1; end
      DIVU:  begin e.res = (b == 0) ? '1 : a / b; e.lat = W + 1; end
      REMU:  begin e.res = (b == 0) ? a : a % b;  e.lat = W + 1; end
`endif
      default: e_ill = 1'b1;
    endcase
    e.flg = {e_eq, e_lt, e_ill};
    return e;
  endfunction

  // Issue one request, wait for the result (out_ready assumed high), compare against the scoreboard.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int cyc;
    @(negedge clk);
    alu_ctrl = op; op1 = a; op2 = b; in_valid = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom; alu_ctrl = 4'($urandom);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    checks++;
    if (cyc !== e.lat) begin
      errors++;
      $display("FAIL latency op=%h a=%h b=%h: got %0d cycles, required %0d", op, a, b, cyc, e.lat);
    end
    checks++;
    if (alu_out !== e.res) begin
      errors++;
      $display("FAIL alu_out op=%h a=%h b=%h: got %h, required %h", op, a, b, alu_out, e.res);
    end
    checks++;
    if ({eq, lt, illegal} !== e.flg) begin
      errors++;
      $display("FAIL flags op=%h a=%h b=%h: got eq/lt/ill=%b, required %b", op, a, b, {eq, lt, illegal}, e.flg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_ctrl = '0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (alu_out !== '0) begin errors++; $display("FAIL reset_alu_out: got %h, required 0", alu_out); end
    checks++;
    if ({eq, lt, illegal} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, required 000", {eq, lt, illegal});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_single_cycle();
    run_op(ADD, 32'hFFFF_FFFF, 32'h1);
    run_op(SRA, 32'h8000_0000, 32'h24);
    run_op(SLT, 32'hFFFF_FFFF, 32'h1);
    run_op(SLTU, 32'hFFFF_FFFF, 32'h1);
    run_op(SUB, 32'h0, 32'h1);
    run_op(AND_, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op(OR_, 32'hF000_0000, 32'h0000_000F);
    run_op(XOR_, 32'hAAAA_5555, 32'hFFFF_0000);
    run_op(SLL, 32'h0000_0003, 32'hFFFF_FFFF);
    run_op(SRL, 32'h8000_0000, 32'h1F);
    run_op(BGE, 32'h0000_0005, 32'h0000_0005);
    run_op(BGE, 32'h8000_0000, 32'h0000_0001);
    run_op(ADD, 32'h1234_5678, 32'h1234_5678);
    run_op(RSVD, 32'h1, 32'h2);
  endtask

  task automatic test_muldiv();
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(DIVU, 32'd100, 32'd0);
    run_op(REMU, 32'd100, 32'd0);
    run_op(DIVU, 32'd100, 32'd7);
    run_op(REMU, 32'd100, 32'd7);
    run_op(MUL, 32'h0001_0003, 32'h0002_0005);
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc;
    out_ready = 1'b0;
    @(negedge clk);
    alu_ctrl = ADD; op1 = 32'd5; op2 = 32'd7; in_valid = 1'b1;
    sb_q.push_back(model(ADD, 32'd5, 32'd7));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_ctrl = SUB; op1 = 32'(i * 3 + 100); op2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_handshake cycle %0d: got out_valid=%b in_ready=%b, required 1/0", i, out_valid, in_ready);
      end
      checks++;
      if (alu_out !== e.res || {eq, lt, illegal} !== e.flg) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got %h/%b, required %h/%b", i, alu_out, {eq, lt, illegal}, e.res, e.flg);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    cyc = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) cyc++; end
    checks++;
    if (cyc !== 0) begin
      errors++; $display("FAIL bp_ignored: got %0d spurious out_valid cycles, required 0", cyc);
    end
  endtask

  task automatic test_reset_busy();
    int cyc;
    out_ready = 1'b0;
    @(negedge clk);
    alu_ctrl = DIVU; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (alu_out !== '0 || {eq, lt, illegal} !== 3'b000) begin
      errors++;
      $display("FAIL rst_busy_outputs: got %h/%b, required 0/000", alu_out, {eq, lt, illegal});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_in_ready: got %b, required 1", in_ready); end
    out_ready = 1'b1;
    cyc = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) cyc++; end
    checks++;
    if (cyc !== 0) begin
      errors++; $display("FAIL rst_busy_stale: got %0d stale out_valid cycles, required 0", cyc);
    end
    run_op(RSVD, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pats[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0013};
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = (i % 2 == 0) ? pats[$urandom_range(0, 5)] : $urandom;
      b = (i % 3 == 0) ? pats[$urandom_range(0, 5)] : $urandom;
      run_op(4'(i), a, b);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
